sdp_y_mul_core_cfg_triosy_seq: RTL and testbench

Per-layer sequencer for the config-resource "triosy" (config-consumed) handshakes of the SDP Y mul core (cfg_truncate, cfg_scale, cfg_shift, cfg_precision, ...).
- Captures a layer's element count and a release mask.
- Counts datapath element acceptances, then waits out the pipeline drain.
- Drives the per-resource oswt toward each triosy wait-ctrl, then pulses the triosy lz outputs once the core write-enable allows completion.
- Sits between the core main FSM and the per-resource triosy wait-ctrl/dp instances.

---
 rtl/sdp_y_mul_core_cfg_triosy_seq.sv | 125 ++++++++++++
 tb/tb_sdp_y_mul_core_cfg_triosy_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdp_y_mul_core_cfg_triosy_seq.sv
// Per-layer triosy sequencer: count element accepts, drain the pipe, release cfg resources.
// Optional stall counter output enabled by SDP_Y_CFG_TRIOSY_PERF_EN.
module sdp_y_mul_core_cfg_triosy_seq #(
    parameter int NUM_CFG   = 4,
    parameter int LEN_W     = 16,
    parameter int DRAIN_CYC = 3
) (
    input  logic               nvdla_core_clk,
    input  logic               nvdla_core_rst,
    input  logic               cfg_load,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic [NUM_CFG-1:0] cfg_mask,
    input  logic               core_wen,
    input  logic               elem_vld,
    output logic               busy,
    output logic [NUM_CFG-1:0] cfg_oswt,
    output logic [NUM_CFG-1:0] cfg_triosy_lz,
    output logic               layer_done,
    output logic               err_load_busy
`ifdef SDP_Y_CFG_TRIOSY_PERF_EN
    ,
    output logic [31:0]        stall_cnt
`endif
);

    localparam int DW = (DRAIN_CYC > 0) ? $clog2(DRAIN_CYC + 1) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, RELEASE} state_t;

    state_t             r_state, w_state_nx;
    logic [LEN_W-1:0]   r_elem_cnt, w_elem_cnt_nx;
    logic [LEN_W-1:0]   r_len_q, w_len_nx;
    logic [NUM_CFG-1:0] r_mask_q, w_mask_nx;
    logic [DW-1:0]      r_drain_cnt, w_drain_nx;
    logic               w_done_nx;
    logic               w_load_acc;

    assign w_load_acc = cfg_load && (r_state == IDLE);

    always_comb begin
        w_state_nx    = r_state;
        w_elem_cnt_nx = r_elem_cnt;
        w_len_nx      = r_len_q;
        w_mask_nx     = r_mask_q;
        w_drain_nx    = r_drain_cnt;
        w_done_nx     = 1'b0;
        case (r_state)
            IDLE: begin
                if (cfg_load) begin
                    w_state_nx    = RUN;
                    w_len_nx      = cfg_len;
                    w_mask_nx     = cfg_mask;
                    w_elem_cnt_nx = '0;
                end
            end
            RUN: begin
                if (elem_vld && core_wen) begin
                    // Compare before increment so a full-scale len never wraps the counter.
                    if (r_elem_cnt == r_len_q) begin
                        w_state_nx = (DRAIN_CYC == 0) ? RELEASE : DRAIN;
                        w_drain_nx = DW'(DRAIN_CYC);
                    end else begin
                        w_elem_cnt_nx = r_elem_cnt + LEN_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (core_wen) begin
                    w_drain_nx = r_drain_cnt - DW'(1);
                    if (r_drain_cnt == DW'(1)) w_state_nx = RELEASE;
                end
            end
            RELEASE: begin
                // Same qualifier the wait-ctrl uses for bdwt, so both sides complete together.
                if (core_wen) begin
                    w_state_nx = IDLE;
                    w_done_nx  = 1'b1;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            r_state       <= IDLE;
            r_elem_cnt    <= '0;
            r_len_q       <= '0;
            r_mask_q      <= '0;
            r_drain_cnt   <= '0;
            busy          <= 1'b0;
            cfg_triosy_lz <= '0;
            layer_done    <= 1'b0;
            err_load_busy <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_elem_cnt    <= w_elem_cnt_nx;
            r_len_q       <= w_len_nx;
            r_mask_q      <= w_mask_nx;
            r_drain_cnt   <= w_drain_nx;
            busy          <= (w_state_nx != IDLE);
            cfg_triosy_lz <= w_done_nx ? r_mask_q : '0;
            layer_done    <= w_done_nx;
            if (cfg_load && (r_state != IDLE)) err_load_busy <= 1'b1;
        end
    end

    assign cfg_oswt = (r_state == RELEASE) ? r_mask_q : '0;

`ifdef SDP_Y_CFG_TRIOSY_PERF_EN
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            stall_cnt <= '0;
        end else if (w_load_acc) begin
            stall_cnt <= '0;
        end else if ((r_state != IDLE) && !core_wen && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`else
    logic w_unused;
    assign w_unused = w_load_acc;
`endif

endmodule

// File: tb/tb_sdp_y_mul_core_cfg_triosy_seq.sv
// Bench: two instances (default params; DRAIN_CYC=0 with LEN_W=4) against a countdown-based model.
module tb_sdp_y_mul_core_cfg_triosy_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld = 1'b0, wen = 1'b0, vld = 1'b0;
    logic [15:0] len = '0;
    logic [3:0]  mask = '0;
    logic [3:0]  len0;

    logic        busy1, done1, err1, busy0, done0, err0;
    logic [3:0]  oswt1, lz1, oswt0, lz0;
    logic [31:0] stall1, stall0;

    assign len0 = len[3:0];

    always #5 clk = ~clk;

    sdp_y_mul_core_cfg_triosy_seq #(.NUM_CFG(4), .LEN_W(16), .DRAIN_CYC(3)) dut1 (
        .nvdla_core_clk(clk), .nvdla_core_rst(rst), .cfg_load(ld), .cfg_len(len),
        .cfg_mask(mask), .core_wen(wen), .elem_vld(vld), .busy(busy1), .cfg_oswt(oswt1),
        .cfg_triosy_lz(lz1), .layer_done(done1), .err_load_busy(err1)
`ifdef SDP_Y_CFG_TRIOSY_PERF_EN
        , .stall_cnt(stall1)
`endif
    );

    sdp_y_mul_core_cfg_triosy_seq #(.NUM_CFG(4), .LEN_W(4), .DRAIN_CYC(0)) dut0 (
        .nvdla_core_clk(clk), .nvdla_core_rst(rst), .cfg_load(ld), .cfg_len(len0),
        .cfg_mask(mask), .core_wen(wen), .elem_vld(vld), .busy(busy0), .cfg_oswt(oswt0),
        .cfg_triosy_lz(lz0), .layer_done(done0), .err_load_busy(err0)
`ifdef SDP_Y_CFG_TRIOSY_PERF_EN
        , .stall_cnt(stall0)
`endif
    );

`ifndef SDP_Y_CFG_TRIOSY_PERF_EN
    assign stall1 = '0;
    assign stall0 = '0;
`endif

    // Model: mode 0 idle, 1 counting accepts, 2 draining, 3 releasing.
    typedef struct {
        int          mode;
        int          rem;
        int          dleft;
        logic [3:0]  mask;
        logic        busy;
        logic [3:0]  lz;
        logic        done;
        logic        err;
        logic [31:0] stall;
    } mdl_t;

    typedef struct {
        int          len;
        logic [3:0]  mask;
        logic [31:0] wen_off;
        int          l2_cyc;
        int          l2_len;
        logic [3:0]  l2_mask;
        int          exp_done1;
        int          exp_done0;
        logic [3:0]  exp_lz1;
        logic        exp_err1;
        logic [31:0] exp_stall1;
    } vec_t;

    mdl_t m1, m0;
    vec_t tbl[7];
    int   tests = 0, fails = 0;

    function automatic mdl_t mreset();
        mdl_t m;
        m.mode = 0; m.rem = 0; m.dleft = 0; m.mask = '0; m.busy = 1'b0;
        m.lz = '0; m.done = 1'b0; m.err = 1'b0; m.stall = '0;
        return m;
    endfunction

    function automatic mdl_t step(mdl_t m, logic l, int ln, logic [3:0] mk, logic w, logic v, int dc);
        mdl_t n = m;
        n.lz = '0;
        n.done = 1'b0;
        if (m.mode != 0 && l) n.err = 1'b1;
        if (m.mode != 0 && !w && m.stall != 32'hFFFF_FFFF) n.stall = m.stall + 1;
        case (m.mode)
            0: if (l) begin n.mode = 1; n.rem = ln + 1; n.mask = mk; n.stall = '0; end
            1: if (v && w) begin
                n.rem = m.rem - 1;
                if (n.rem == 0) begin n.mode = (dc == 0) ? 3 : 2; n.dleft = dc; end
            end
            2: if (w) begin n.dleft = m.dleft - 1; if (n.dleft == 0) n.mode = 3; end
            3: if (w) begin n.lz = m.mask; n.done = 1'b1; n.mode = 0; end
            default: n.mode = 0;
        endcase
        n.busy = (n.mode != 0);
        return n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic check_all();
        chk("busy1", {31'd0, busy1}, {31'd0, m1.busy});
        chk("oswt1", {28'd0, oswt1}, {28'd0, (m1.mode == 3) ? m1.mask : 4'd0});
        chk("lz1",   {28'd0, lz1},   {28'd0, m1.lz});
        chk("done1", {31'd0, done1}, {31'd0, m1.done});
        chk("err1",  {31'd0, err1},  {31'd0, m1.err});
        chk("busy0", {31'd0, busy0}, {31'd0, m0.busy});
        chk("oswt0", {28'd0, oswt0}, {28'd0, (m0.mode == 3) ? m0.mask : 4'd0});
        chk("lz0",   {28'd0, lz0},   {28'd0, m0.lz});
        chk("done0", {31'd0, done0}, {31'd0, m0.done});
        chk("err0",  {31'd0, err0},  {31'd0, m0.err});
`ifdef SDP_Y_CFG_TRIOSY_PERF_EN
        chk("stall1", stall1, m1.stall);
        chk("stall0", stall0, m0.stall);
`endif
    endtask

    task automatic apply_and_step(input logic l, input int ln, input logic [3:0] mk,
                                  input logic w, input logic v);
        ld = l; len = ln[15:0]; mask = mk; wen = w; vld = v;
        m1 = step(m1, l, ln & 16'hFFFF, mk, w, v, 3);
        m0 = step(m0, l, ln & 15, mk, w, v, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; ld = 0; len = '0; mask = '0; wen = 0; vld = 0;
        m1 = mreset(); m0 = mreset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_vec(input int i);
        int d1 = -1, d0 = -1;
        logic [3:0] lz_at = '0;
        do_reset();
        for (int k = 0; k < 32; k++) begin
            check_all();
            if (done1 && d1 < 0) begin d1 = k; lz_at = lz1; end
            if (done0 && d0 < 0) d0 = k;
            if (k == 0)
                apply_and_step(1'b1, tbl[i].len, tbl[i].mask, !tbl[i].wen_off[k], 1'b1);
            else if (k == tbl[i].l2_cyc)
                apply_and_step(1'b1, tbl[i].l2_len, tbl[i].l2_mask, !tbl[i].wen_off[k], 1'b1);
            else
                apply_and_step(1'b0, 0, 4'd0, !tbl[i].wen_off[k], 1'b1);
        end
        chk($sformatf("v%0d_done1_cyc", i), d1, tbl[i].exp_done1);
        chk($sformatf("v%0d_done0_cyc", i), d0, tbl[i].exp_done0);
        chk($sformatf("v%0d_lz1", i), {28'd0, lz_at}, {28'd0, tbl[i].exp_lz1});
        chk($sformatf("v%0d_err1", i), {31'd0, err1}, {31'd0, tbl[i].exp_err1});
`ifdef SDP_Y_CFG_TRIOSY_PERF_EN
        chk($sformatf("v%0d_stall1", i), stall1, tbl[i].exp_stall1);
`endif
    endtask

    initial begin
        //           len  mask     wen_off                       l2  l2len l2mask d1  d0  lz1      err stall
        tbl[0] = '{3,  4'b1011, 32'h0,                         -1, 0, 4'h0, 9,  6,  4'b1011, 0, 0};
        tbl[1] = '{3,  4'b1011, (32'h1<<3)|(32'h1<<6)|(32'h7<<8), -1, 0, 4'h0, 14, 8,  4'b1011, 0, 5};
        tbl[2] = '{0,  4'b0001, 32'h0,                         -1, 0, 4'h0, 6,  3,  4'b0001, 0, 0};
        tbl[3] = '{3,  4'b1011, 32'h0,                          4, 9, 4'b0110, 9, 6, 4'b1011, 1, 0};
        tbl[4] = '{1,  4'b0000, 32'h0,                         -1, 0, 4'h0, 7,  4,  4'b0000, 0, 0};
        tbl[5] = '{15, 4'b1111, 32'h0,                         -1, 0, 4'h0, 21, 18, 4'b1111, 0, 0};
        tbl[6] = '{3,  4'b1011, 32'h0,                          8, 0, 4'b0001, 9, 6, 4'b1011, 1, 0};

        // Reset state.
        do_reset();
        check_all();

        for (int i = 0; i < 7; i++) run_vec(i);

        // Load on the layer_done cycle is accepted: no error, second layer runs.
        tbl[6].l2_cyc = 9;
        tbl[6].exp_err1 = 0;
        run_vec(6);

        // Async reset mid-DRAIN, with error already flagged.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            check_all();
            apply_and_step(k == 0 || k == 4, (k == 0) ? 3 : 9, (k == 0) ? 4'b1011 : 4'b0110, 1'b1, 1'b1);
        end
        check_all();
        chk("pre_rst_busy", {31'd0, busy1}, 32'd1);
        chk("pre_rst_err", {31'd0, err1}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_busy", {31'd0, busy1}, 32'd0);
        chk("rst_oswt", {28'd0, oswt1}, 32'd0);
        chk("rst_lz", {28'd0, lz1}, 32'd0);
        chk("rst_done", {31'd0, done1}, 32'd0);
        chk("rst_err", {31'd0, err1}, 32'd0);
        run_vec(0);

        // Randomized traffic.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            check_all();
            apply_and_step($urandom_range(0, 15) == 0, $urandom_range(0, 20),
                           4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
                           $urandom_range(0, 3) != 0);
        end
        check_all();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
